pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline controller for the 3-stage core (pc_reg → if_id → id_ex → ex → regs). Sequences branch/jump redirects with a timed flush window. Stalls the pipeline while the multi-cycle mul/div unit runs. Owns the single regs write port, arbitrating between the ex result and the mul/div result.

Parameters:
FLUSH_CYC, 2, cycles flush_o stays high after an accepted jump (1..15)
MD_TIMEOUT, 64, max cycles in MD_BUSY before abort (2..127)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
jump_en_i  input  1  ex requests redirect (level, qualified by state)
jump_addr_i  input  32  redirect target
md_req_i  input  1  ex holds a mul/div instruction
md_rd_addr_i  input  5  destination of the mul/div instruction
md_done_i  input  1  mul/div unit result valid (1-cycle pulse)
md_result_i  input  32  mul/div result
ex_rd_wen_i  input  1  ex single-cycle write enable
ex_rd_addr_i  input  5  ex write address
ex_rd_data_i  input  32  ex write data
pc_load_o  output  1  load pc with pc_load_addr_o
pc_load_addr_o  output  32  redirect target
flush_o  output  1  bubble if_id and id_ex
hold_o  output  3  {pc, if_id, id_ex} hold enables
md_start_o  output  1  start pulse to mul/div unit
md_abort_o  output  1  1-cycle pulse on timeout
md_err_o  output  1  sticky timeout flag
rd_wen_o  output  1  regs write enable
rd_addr_o  output  5  regs write address
rd_data_o  output  32  regs write data
stall_cnt_o  output  32  stall statistic (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE, counters 0, latched addr 0, md_err_o 0; all outputs 0.
- States: IDLE, FLUSH, MD_BUSY, MD_WB.
- IDLE:
  - rd_* = ex_rd_* combinationally.
  - jump_en_i=1: pc_load_o=1 and pc_load_addr_o=jump_addr_i in the same cycle; flush_o=1. If FLUSH_CYC>1, go to FLUSH with flush_cnt=FLUSH_CYC-1; otherwise stay in IDLE.
  - md_req_i=1 (and jump_en_i=0): md_start_o=1 for this cycle only; latch md_rd_addr_i; timeout counter=0; go to MD_BUSY. The ex write is suppressed this cycle (rd_wen_o=0).
  - jump_en_i and md_req_i both high: jump wins; md_req_i ignored.
- FLUSH: flush_o=1; decrement flush_cnt; return to IDLE when flush_cnt reaches 0. hold_o=0. jump_en_i and md_req_i ignored. rd_* pass ex_rd_* (ex carries bubbles).
- MD_BUSY:
  - hold_o=3'b111; rd_wen_o=0; jump_en_i and md_req_i ignored.
  - md_done_i=1: register md_result_i; go to MD_WB.
  - Otherwise increment counter. Reaching MD_TIMEOUT gives md_abort_o=1 for 1 cycle, sets md_err_o, and returns to IDLE with no writeback.
  - md_done_i in the same cycle as the timeout hit: done wins, no abort.
- MD_WB: rd_wen_o=1, rd_addr_o=latched addr, rd_data_o=registered result; hold_o=3'b111; next cycle IDLE with hold released.
- Total stall for an op whose md_done_i arrives N cycles after md_start_o: N+1 held cycles.
- x0 rule: rd_wen_o forced 0 whenever rd_addr_o==0, in every state.
- md_done_i outside MD_BUSY: ignored.
- md_err_o: cleared only by reset.
- Reset mid-operation: immediate return to IDLE, result discarded, no writeback.

Optional Feature:
Macro CTRL_STALL_STAT_EN.
- Defined: stall_cnt_o is a 32-bit counter, reset 0, incremented each cycle hold_o!=0 or flush_o=1; wraps 0xFFFFFFFF→0.
- Undefined: stall_cnt_o tied to 0, no counter flops.

Test Plan:
- ex write: IDLE, ex_rd_wen_i=1, addr=5, data=0x1234 → same cycle rd_wen_o=1, rd_addr_o=5, rd_data_o=0x1234. Repeat with addr=0 → rd_wen_o=0.
- Jump, FLUSH_CYC=2: jump_en_i=1, addr=0x100 → pc_load_o=1 and addr 0x100 in that cycle; flush_o high for exactly 2 cycles. A second jump_en_i in cycle 2 is ignored.
- Mul/div: md_req_i=1, rd=7; md_done_i 5 cycles after md_start_o with result 0xDEADBEEF → md_start_o 1 cycle; hold_o=3'b111 for 6 cycles; single write x7=0xDEADBEEF in the MD_WB cycle; IDLE after.
- Timeout, MD_TIMEOUT=8: md_req_i with no done → md_abort_o pulse 8 cycles after entry; md_err_o=1 and stays set; no rd_wen_o; hold released.
- Priority and reset: jump_en_i and md_req_i together → jump taken, md_start_o=0. Separately, assert rst_n=0 mid MD_BUSY → all outputs 0 asynchronously; after release, state IDLE and no late writeback when md_done_i arrives.
- Statistic (CTRL_STALL_STAT_EN defined): jump sequence then 5-cycle mul/div → stall_cnt_o=2+6=8; macro undefined → stall_cnt_o stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline controller for the 3-stage core.
//   - branch/jump redirect with a FLUSH_CYC-cycle flush window
//   - pipeline hold while the multi-cycle mul/div unit runs, with timeout abort
//   - owner of the single regs write port (ex result vs. mul/div result)
// Optional feature macro: CTRL_STALL_STAT_EN (stall statistic counter on stall_cnt_o).
module pipe_ctrl #(
  parameter int FLUSH_CYC  = 2,   // 1..15
  parameter int MD_TIMEOUT = 64   // 2..127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        md_req_i,
  input  logic [4:0]  md_rd_addr_i,
  input  logic        md_done_i,
  input  logic [31:0] md_result_i,
  input  logic        ex_rd_wen_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [31:0] ex_rd_data_i,
  output logic        pc_load_o,
  output logic [31:0] pc_load_addr_o,
  output logic        flush_o,
  output logic [2:0]  hold_o,
  output logic        md_start_o,
  output logic        md_abort_o,
  output logic        md_err_o,
  output logic        rd_wen_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, MD_BUSY, MD_WB} state_e;

  // Regs write-port request, muxed between ex and mul/div writeback.
  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);
  localparam logic [6:0] TO_LAST    = 7'(MD_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [6:0]  to_cnt_q, to_cnt_d;
  logic [4:0]  md_rd_q, md_rd_d;
  logic [31:0] md_res_q, md_res_d;
  logic        md_err_q, md_err_d;

  logic        pc_load, flush, md_start, md_abort;
  logic [2:0]  hold;
  logic [31:0] pc_addr;
  wr_req_t     wr;

  // State and datapath registers; reset drops any in-flight mul/div op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      to_cnt_q    <= '0;
      md_rd_q     <= '0;
      md_res_q    <= '0;
      md_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      to_cnt_q    <= to_cnt_d;
      md_rd_q     <= md_rd_d;
      md_res_q    <= md_res_d;
      md_err_q    <= md_err_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    to_cnt_d    = to_cnt_q;
    md_rd_d     = md_rd_q;
    md_res_d    = md_res_q;
    md_err_d    = md_err_q;
    pc_load     = 1'b0;
    pc_addr     = '0;
    flush       = 1'b0;
    hold        = 3'b000;
    md_start    = 1'b0;
    md_abort    = 1'b0;
    wr.wen      = ex_rd_wen_i;
    wr.addr     = ex_rd_addr_i;
    wr.data     = ex_rd_data_i;
    unique case (state_q)
      IDLE: begin
        if (jump_en_i) begin
          // Jump beats a simultaneous mul/div request.
          pc_load = 1'b1;
          pc_addr = jump_addr_i;
          flush   = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (md_req_i) begin
          md_start = 1'b1;
          wr.wen   = 1'b0;
          md_rd_d  = md_rd_addr_i;
          to_cnt_d = '0;
          state_d  = MD_BUSY;
        end
      end
      FLUSH: begin
        // ex carries bubbles here, so its write port passes straight through.
        flush       = 1'b1;
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q == 4'd1) state_d = IDLE;
      end
      MD_BUSY: begin
        hold   = 3'b111;
        wr.wen = 1'b0;
        if (md_done_i) begin
          // done wins over a coincident timeout
          md_res_d = md_result_i;
          state_d  = MD_WB;
        end else if (to_cnt_q == TO_LAST) begin
          md_abort = 1'b1;
          md_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 7'd1;
        end
      end
      MD_WB: begin
        hold    = 3'b111;
        wr.wen  = 1'b1;
        wr.addr = md_rd_q;
        wr.data = md_res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // x0 is hardwired zero: never write it.
    if (wr.addr == 5'd0) wr.wen = 1'b0;
  end

  // Combinational outputs are gated by reset so everything reads 0 while held in reset.
  assign pc_load_o      = rst_n & pc_load;
  assign pc_load_addr_o = {32{rst_n}} & pc_addr;
  assign flush_o        = rst_n & flush;
  assign hold_o         = {3{rst_n}} & hold;
  assign md_start_o     = rst_n & md_start;
  assign md_abort_o     = rst_n & md_abort;
  assign md_err_o       = md_err_q;
  assign rd_wen_o       = rst_n & wr.wen;
  assign rd_addr_o      = {5{rst_n}} & wr.addr;
  assign rd_data_o      = {32{rst_n}} & wr.data;

`ifdef CTRL_STALL_STAT_EN
  logic [31:0] stall_cnt_q;

  // Count every cycle the front of the pipe is held or flushed; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt_q <= '0;
    else if ((hold != 3'b000) || flush) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized bench for pipe_ctrl against a cycle-count model.
module tb_pipe_ctrl;
  localparam int FC = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en_i = 0, md_req_i = 0, md_done_i = 0, ex_rd_wen_i = 0;
  logic [31:0] jump_addr_i = 0, md_result_i = 0, ex_rd_data_i = 0;
  logic [4:0]  md_rd_addr_i = 0, ex_rd_addr_i = 0;
  logic        pc_load_o, flush_o, md_start_o, md_abort_o, md_err_o, rd_wen_o;
  logic [31:0] pc_load_addr_o, rd_data_o, stall_cnt_o;
  logic [2:0]  hold_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int failures = 0;

  pipe_ctrl #(.FLUSH_CYC(FC), .MD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .md_req_i(md_req_i), .md_rd_addr_i(md_rd_addr_i),
    .md_done_i(md_done_i), .md_result_i(md_result_i),
    .ex_rd_wen_i(ex_rd_wen_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i),
    .pc_load_o(pc_load_o), .pc_load_addr_o(pc_load_addr_o), .flush_o(flush_o),
    .hold_o(hold_o), .md_start_o(md_start_o), .md_abort_o(md_abort_o),
    .md_err_o(md_err_o), .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: remaining flush cycles, age of the pending mul/div op (-1 = none),
  // pending writeback flag, latched destination/result, sticky error, stall total.
  int          m_flush_rem = 0;
  int          m_age = -1;
  bit          m_wb = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_res = 0;
  bit          m_err = 0;
  logic [31:0] m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_rem = 0; m_age = -1; m_wb = 0; m_rd = 0; m_res = 0; m_err = 0; m_stall = 0;
  endtask

  task automatic idle_inputs();
    jump_en_i = 0; md_req_i = 0; md_done_i = 0; ex_rd_wen_i = 0;
    jump_addr_i = 0; md_result_i = 0; ex_rd_data_i = 0; md_rd_addr_i = 0; ex_rd_addr_i = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cyc();
    bit e_pcl, e_flush, e_start, e_abort, e_wen, busy;
    logic [2:0]  e_hold;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int n_flush_rem, n_age; bit n_wb, n_err; logic [4:0] n_rd; logic [31:0] n_res;
    @(negedge clk);
    e_pcl = 0; e_flush = 0; e_start = 0; e_abort = 0; e_hold = 0; busy = 0;
    e_wen = ex_rd_wen_i; e_addr = ex_rd_addr_i; e_data = ex_rd_data_i;
    n_flush_rem = m_flush_rem; n_age = m_age; n_wb = m_wb; n_err = m_err; n_rd = m_rd; n_res = m_res;
    if (m_wb) begin
      e_wen = 1; e_addr = m_rd; e_data = m_res; e_hold = 3'b111; n_wb = 0;
    end else if (m_age >= 0) begin
      busy = 1; e_hold = 3'b111; e_wen = 0;
      if (md_done_i) begin n_age = -1; n_wb = 1; n_res = md_result_i; end
      else if (m_age + 1 == TO) begin e_abort = 1; n_err = 1; n_age = -1; end
      else n_age = m_age + 1;
    end else if (m_flush_rem > 0) begin
      e_flush = 1; n_flush_rem = m_flush_rem - 1;
    end else if (jump_en_i) begin
      e_pcl = 1; e_flush = 1; n_flush_rem = FC - 1;
    end else if (md_req_i) begin
      e_start = 1; e_wen = 0; n_rd = md_rd_addr_i; n_age = 0;
    end
    if (e_addr == 5'd0) e_wen = 0;
    chk("pc_load", 32'(pc_load_o), 32'(e_pcl));
    if (e_pcl) chk("pc_load_addr", pc_load_addr_o, jump_addr_i);
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("hold", 32'(hold_o), 32'(e_hold));
    chk("md_start", 32'(md_start_o), 32'(e_start));
    chk("md_abort", 32'(md_abort_o), 32'(e_abort));
    chk("md_err", 32'(md_err_o), 32'(m_err));
    chk("rd_wen", 32'(rd_wen_o), 32'(e_wen));
    if (!busy) begin
      chk("rd_addr", 32'(rd_addr_o), 32'(e_addr));
      chk("rd_data", rd_data_o, e_data);
    end
`ifdef CTRL_STALL_STAT_EN
    chk("stall_cnt", stall_cnt_o, m_stall);
`else
    chk("stall_cnt", stall_cnt_o, 32'd0);
`endif
    @(posedge clk);
    if (e_hold != 0 || e_flush) m_stall = m_stall + 32'd1;
    m_flush_rem = n_flush_rem; m_age = n_age; m_wb = n_wb; m_err = n_err; m_rd = n_rd; m_res = n_res;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc_load"}, 32'(pc_load_o), 0);
    chk({tag, "_pc_addr"}, pc_load_addr_o, 0);
    chk({tag, "_flush"}, 32'(flush_o), 0);
    chk({tag, "_hold"}, 32'(hold_o), 0);
    chk({tag, "_md_start"}, 32'(md_start_o), 0);
    chk({tag, "_md_abort"}, 32'(md_abort_o), 0);
    chk({tag, "_md_err"}, 32'(md_err_o), 0);
    chk({tag, "_rd_wen"}, 32'(rd_wen_o), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr_o), 0);
    chk({tag, "_rd_data"}, rd_data_o, 0);
    chk({tag, "_stall"}, stall_cnt_o, 0);
  endtask

  initial begin
    // Reset state
    idle_inputs();
    #2 chk_all_zero("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;

    // Jump to 0x100; a second jump during the flush window is ignored.
    jump_en_i = 1; jump_addr_i = 32'h100; cyc();
    jump_addr_i = 32'h200; cyc();
    jump_en_i = 0; cyc();

    // Mul/div to x7, done 5 cycles after start.
    md_req_i = 1; md_rd_addr_i = 5'd7; cyc();
    md_req_i = 0;
    repeat (4) cyc();
    md_done_i = 1; md_result_i = 32'hDEADBEEF; cyc();
    md_done_i = 0; md_result_i = 0; cyc();   // writeback cycle
    cyc();
`ifdef CTRL_STALL_STAT_EN
    chk("stall_total", stall_cnt_o, 32'd8);
`else
    chk("stall_total", stall_cnt_o, 32'd0);
`endif

    // ex writes: x5 passes, x0 suppressed
    ex_rd_wen_i = 1; ex_rd_addr_i = 5'd5; ex_rd_data_i = 32'h1234; cyc();
    ex_rd_addr_i = 5'd0; cyc();
    idle_inputs();

    // Timeout: no done ever arrives
    md_req_i = 1; md_rd_addr_i = 5'd9; cyc();
    md_req_i = 0;
    repeat (TO + 2) cyc();
    chk("err_sticky", 32'(md_err_o), 32'd1);

    // Jump and mul/div together: jump wins
    jump_en_i = 1; md_req_i = 1; md_rd_addr_i = 5'd3; jump_addr_i = 32'h40; cyc();
    idle_inputs(); cyc(); cyc();

    // Reset in the middle of MD_BUSY, with live inputs on the ports
    md_req_i = 1; md_rd_addr_i = 5'd12; cyc();
    md_req_i = 0; cyc(); cyc();
    jump_en_i = 1; jump_addr_i = 32'h55; ex_rd_wen_i = 1; ex_rd_addr_i = 5'd5; ex_rd_data_i = 32'h77;
    #2 rst_n = 0;
    #1 chk_all_zero("midrst");
    idle_inputs();
    @(negedge clk) rst_n = 1;
    model_reset();
    @(posedge clk) #1;
    md_done_i = 1; md_result_i = 32'hCAFEF00D; cyc();
    md_done_i = 0; cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      jump_en_i    = ($urandom_range(0, 7) == 0);
      jump_addr_i  = $urandom;
      md_req_i     = ($urandom_range(0, 5) == 0);
      md_rd_addr_i = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      md_done_i    = ($urandom_range(0, 5) == 0);
      md_result_i  = $urandom;
      ex_rd_wen_i  = 1'($urandom);
      ex_rd_addr_i = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      ex_rd_data_i = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
